// File: rtl/instr_mem_pipe.sv
// Instruction store with boot-load write port and registered fetch port (BOOT -> LOAD -> RUN).
// Fetch latency: READ_LAT cycles (1 or 2) from acceptance to fetch_valid; load writes take effect next edge.
// No backpressure: one fetch accepted per cycle while fetch_ready; entering LOAD flushes in-flight responses.
module instr_mem_pipe #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                READ_LAT    = 1,
    parameter logic [DATA_W-1:0] RESET_INSTR = 32'h00000013,
    parameter int                LA_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [LA_W-1:0]   load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [LA_W:0]     load_count,
    output logic              fetch_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int              IDX_W    = ADDR_W - 2;
    localparam logic [LA_W:0]   DEPTH_LC = (LA_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IX = IDX_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_load;
    logic             enter_load;
    logic             flush;
    logic             wr_ok;
    logic [IDX_W-1:0] f_idx;
    logic             f_acc;
    logic             f_bad;
    logic             rd_en;
    logic [DATA_W-1:0] rd_dat;
    logic             s1_vld;
    logic             s1_err;
    logic [DATA_W-1:0] s1_instr;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: if (load_en)  state_nxt = ST_LOAD;
            ST_LOAD: if (!load_en) state_nxt = ST_RUN;
            ST_RUN:  if (load_en)  state_nxt = ST_LOAD;
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    assign in_load     = (state == ST_LOAD);
    assign enter_load  = (state_nxt == ST_LOAD) && !in_load;
    assign flush       = (state == ST_RUN) && load_en;
    assign fetch_ready = (state == ST_RUN);

    // ------------------------------------------------------------------
    // Boot-load write port; the write in the load_en-falling cycle still lands
    // ------------------------------------------------------------------
    assign wr_ok = in_load && load_we && ({1'b0, load_addr} < DEPTH_LC);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            load_count <= '0;
        end else if (enter_load) begin
            load_count <= '0;
        end else if (wr_ok && (load_count != DEPTH_LC)) begin
            load_count <= load_count + (LA_W + 1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Fetch stage 1: synchronous array read plus valid/error flags
    // ------------------------------------------------------------------
    assign f_idx = fetch_addr[ADDR_W-1:2];
    // A request presented in the cycle that switches back to LOAD is dropped with the flush.
    assign f_acc = fetch_ready && fetch_req && !load_en;
    assign f_bad = (fetch_addr[1:0] != 2'b00) || (f_idx >= DEPTH_IX);
    assign rd_en = f_acc && !f_bad;

    // Data register has no reset so the array read maps onto a RAM output port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= mem[f_idx[LA_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= f_acc;
            s1_err <= f_acc && f_bad;
        end
    end

    assign s1_instr = (s1_vld && !s1_err) ? rd_dat : RESET_INSTR;

    // ------------------------------------------------------------------
    // Optional second stage
    // ------------------------------------------------------------------
    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic              s2_vld;
            logic              s2_err;
            logic [DATA_W-1:0] s2_instr;

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    s2_vld   <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_instr <= RESET_INSTR;
                end else if (flush) begin
                    s2_vld   <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_instr <= RESET_INSTR;
                end else begin
                    s2_vld   <= s1_vld;
                    s2_err   <= s1_err;
                    s2_instr <= s1_instr;
                end
            end

            assign fetch_valid = s2_vld;
            assign fetch_err   = s2_err;
            assign fetch_instr = s2_instr;
        end else begin : g_lat1
            assign fetch_valid = s1_vld;
            assign fetch_err   = s1_err;
            assign fetch_instr = s1_instr;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: three instances (DEPTH 1024 lat 1, DEPTH 1024 lat 2, DEPTH 5 lat 1)
// share one stimulus stream; responses are checked against per-instance scoreboards every cycle.
module tb_instr_mem_pipe;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        load_en;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        fetch_req;
    logic [31:0] fetch_addr;

    logic [10:0] b1_cnt, b2_cnt;
    logic [3:0]  s_cnt;
    logic        b1_rdy, b2_rdy, s_rdy;
    logic        b1_vld, b2_vld, s_vld;
    logic        b1_err, b2_err, s_err;
    logic [31:0] b1_ins, b2_ins, s_ins;

    always #5 clk = ~clk;

    instr_mem_pipe #(.READ_LAT(1)) u_big1 (
        .clk(clk), .rst_l(rst_l), .load_en(load_en), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .load_count(b1_cnt),
        .fetch_ready(b1_rdy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(b1_vld), .fetch_instr(b1_ins), .fetch_err(b1_err)
    );

    instr_mem_pipe #(.READ_LAT(2)) u_big2 (
        .clk(clk), .rst_l(rst_l), .load_en(load_en), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .load_count(b2_cnt),
        .fetch_ready(b2_rdy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(b2_vld), .fetch_instr(b2_ins), .fetch_err(b2_err)
    );

    instr_mem_pipe #(.DEPTH(5), .READ_LAT(1)) u_small (
        .clk(clk), .rst_l(rst_l), .load_en(load_en), .load_we(load_we),
        .load_addr(load_addr[2:0]), .load_data(load_data), .load_count(s_cnt),
        .fetch_ready(s_rdy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(s_vld), .fetch_instr(s_ins), .fetch_err(s_err)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] ins;
    } rsp_t;

    typedef struct {
        logic        en;
        logic        we;
        logic [9:0]  a;
        logic [31:0] d;
        int          cb;
        int          cs;
    } ld_vec_t;

    typedef struct {
        logic [31:0] a;
        logic        eb;
        logic        es;
        logic [31:0] ins_b;
        logic [31:0] ins_s;
    } fv_t;

    rsp_t q_b1[$];
    rsp_t q_b2[$];
    rsp_t q_s[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ld_vec_t ld_tab[10];
    fv_t     f_tab[12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input string nm, input logic vld, input logic err, input logic [31:0] ins,
                       input bit ev, input rsp_t e);
        check({nm, " fetch_valid"}, 32'(vld), 32'(ev));
        if (ev) begin
            check({nm, " fetch_err"}, 32'(err), 32'(e.err));
            check({nm, " fetch_instr"}, ins, e.ins);
        end else begin
            check({nm, " idle fetch_instr"}, ins, NOP);
        end
    endtask

    always @(negedge clk) begin : mon_blk
        rsp_t e;
        bit   v;
        e.due = 0; e.err = 1'b0; e.ins = NOP;
        v = (q_b1.size() > 0) && (q_b1[0].due == cyc);
        if (v) e = q_b1.pop_front();
        mon("big1", b1_vld, b1_err, b1_ins, v, e);
        e.due = 0; e.err = 1'b0; e.ins = NOP;
        v = (q_b2.size() > 0) && (q_b2[0].due == cyc);
        if (v) e = q_b2.pop_front();
        mon("big2", b2_vld, b2_err, b2_ins, v, e);
        e.due = 0; e.err = 1'b0; e.ins = NOP;
        v = (q_s.size() > 0) && (q_s[0].due == cyc);
        if (v) e = q_s.pop_front();
        mon("small", s_vld, s_err, s_ins, v, e);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_sb();
        q_b1.delete();
        q_b2.delete();
        q_s.delete();
    endtask

    task automatic check_rdy(input logic exp);
        check("big1 fetch_ready", 32'(b1_rdy), 32'(exp));
        check("big2 fetch_ready", 32'(b2_rdy), 32'(exp));
        check("small fetch_ready", 32'(s_rdy), 32'(exp));
    endtask

    task automatic check_cnt(input int cb, input int cs);
        check("big1 load_count", 32'(b1_cnt), cb);
        check("big2 load_count", 32'(b2_cnt), cb);
        check("small load_count", 32'(s_cnt), cs);
    endtask

    task automatic load_step(input logic en, input logic we, input logic [9:0] a,
                             input logic [31:0] d, input int cb, input int cs);
        load_en   = en;
        load_we   = we;
        load_addr = a;
        load_data = d;
        step();
        load_we = 1'b0;
        check_cnt(cb, cs);
    endtask

    // Responses appear at the negedge READ_LAT-1 cycles after the accepting edge.
    task automatic fetch_step(input logic [31:0] a, input logic eb, input logic es,
                              input logic [31:0] ib, input logic [31:0] is_);
        rsp_t r;
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req = 1'b0;
        r.err = eb; r.ins = eb ? NOP : ib;
        r.due = cyc;     q_b1.push_back(r);
        r.due = cyc + 1; q_b2.push_back(r);
        r.err = es; r.ins = es ? NOP : is_;
        r.due = cyc;     q_s.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // en, we, addr, data, count big, count small (after the edge)
        ld_tab[0] = '{1'b1, 1'b1, 10'd0, 32'h0062E233, 1, 1};
        ld_tab[1] = '{1'b1, 1'b1, 10'd1, 32'hFFC4A303, 2, 2};
        ld_tab[2] = '{1'b1, 1'b1, 10'd2, 32'h0064A423, 3, 3};
        ld_tab[3] = '{1'b1, 1'b1, 10'd3, 32'hFE420AE3, 4, 4};
        ld_tab[4] = '{1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 5, 4};
        ld_tab[5] = '{1'b1, 1'b1, 10'd4, 32'h00A00513, 6, 5};
        ld_tab[6] = '{1'b1, 1'b1, 10'd7, 32'h12345678, 7, 5};
        ld_tab[7] = '{1'b1, 1'b1, 10'd4, 32'h00A00513, 8, 5};
        ld_tab[8] = '{1'b1, 1'b0, 10'd6, 32'h0BADF00D, 8, 5};
        ld_tab[9] = '{1'b0, 1'b1, 10'd6, 32'h00B00593, 9, 5};

        // addr, err big, err small, instr big, instr small
        f_tab[0]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0062E233, 32'h0062E233};
        f_tab[1]  = '{32'h0000_0004, 1'b0, 1'b0, 32'hFFC4A303, 32'hFFC4A303};
        f_tab[2]  = '{32'h0000_0008, 1'b0, 1'b0, 32'h0064A423, 32'h0064A423};
        f_tab[3]  = '{32'h0000_000C, 1'b0, 1'b0, 32'hFE420AE3, 32'hFE420AE3};
        f_tab[4]  = '{32'h0000_0010, 1'b0, 1'b0, 32'h00A00513, 32'h00A00513};
        f_tab[5]  = '{32'h0000_0014, 1'b0, 1'b1, 32'hDEADBEEF, NOP};
        f_tab[6]  = '{32'h0000_0018, 1'b0, 1'b1, 32'h00B00593, NOP};
        f_tab[7]  = '{32'h0000_0006, 1'b1, 1'b1, NOP, NOP};
        f_tab[8]  = '{32'h0000_1000, 1'b1, 1'b1, NOP, NOP};
        f_tab[9]  = '{32'h0000_001C, 1'b0, 1'b1, 32'h12345678, NOP};
        f_tab[10] = '{32'hFFFF_FFFC, 1'b1, 1'b1, NOP, NOP};
        f_tab[11] = '{32'h0000_0002, 1'b1, 1'b1, NOP, NOP};

        rst_l = 1'b0; load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        fetch_req = 1'b0; fetch_addr = '0;
        repeat (3) step();

        check_rdy(1'b0);
        check_cnt(0, 0);
        check("big1 reset fetch_err", 32'(b1_err), 32'd0);
        check("big2 reset fetch_err", 32'(b2_err), 32'd0);
        check("small reset fetch_err", 32'(s_err), 32'd0);

        rst_l = 1'b1;
        step();
        check_rdy(1'b0);
        // fetch attempted in BOOT must produce nothing
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step();
        fetch_req = 1'b0;
        load_en = 1'b1;
        step();
        check_rdy(1'b0);
        check_cnt(0, 0);

        for (int i = 0; i < 10; i++)
            load_step(ld_tab[i].en, ld_tab[i].we, ld_tab[i].a, ld_tab[i].d, ld_tab[i].cb, ld_tab[i].cs);
        check_rdy(1'b1);

        for (int i = 0; i < 12; i++)
            fetch_step(f_tab[i].a, f_tab[i].eb, f_tab[i].es, f_tab[i].ins_b, f_tab[i].ins_s);
        repeat (3) step();

        // Flush: two fetches in flight, then back to LOAD with a request still presented
        fetch_step(32'h4, 1'b0, 1'b0, 32'hFFC4A303, 32'hFFC4A303);
        fetch_step(32'h8, 1'b0, 1'b0, 32'h0064A423, 32'h0064A423);
        load_en = 1'b1; fetch_req = 1'b1; fetch_addr = 32'hC;
        step();
        fetch_req = 1'b0;
        flush_sb();
        check_rdy(1'b0);
        check_cnt(0, 0);
        step();
        load_step(1'b1, 1'b1, 10'd0, 32'h00000093, 1, 1);
        load_step(1'b0, 1'b0, 10'd0, 32'h0, 1, 1);
        check_rdy(1'b1);
        fetch_step(32'h0, 1'b0, 1'b0, 32'h00000093, 32'h00000093);
        repeat (3) step();

        // Async reset with a fetch pending; memory must survive it
        fetch_step(32'h8, 1'b0, 1'b0, 32'h0064A423, 32'h0064A423);
        rst_l = 1'b0;
        flush_sb();
        #1;
        check("big1 fetch_valid in reset", 32'(b1_vld), 32'd0);
        check("big2 fetch_valid in reset", 32'(b2_vld), 32'd0);
        check("small fetch_valid in reset", 32'(s_vld), 32'd0);
        check_rdy(1'b0);
        step();
        step();
        rst_l = 1'b1;
        check_cnt(0, 0);
        step();
        check_rdy(1'b0);
        load_step(1'b1, 1'b0, 10'd0, 32'h0, 0, 0);
        load_step(1'b0, 1'b0, 10'd0, 32'h0, 0, 0);
        check_rdy(1'b1);
        fetch_step(32'h0,  1'b0, 1'b0, 32'h00000093, 32'h00000093);
        fetch_step(32'h10, 1'b0, 1'b0, 32'h00A00513, 32'h00A00513);
        fetch_step(32'h14, 1'b0, 1'b1, 32'hDEADBEEF, NOP);
        repeat (4) step();

        check("scoreboard drained", 32'(q_b1.size() + q_b2.size() + q_s.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
Parametrised instruction memory for the RISC-V core. It adds a boot-load write port, a registered fetch port with req/valid handshake and configurable read latency, and error flagging for misaligned or out-of-range fetches. A three-state controller sequences BOOT -> LOAD -> RUN, so the program is written by a loader or testbench before the core fetches. It replaces the combinational, hard-initialised instruction store between the PC register and the decode stage.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 32, byte-address width of fetch_addr
DEPTH, 1024, number of instruction words; need not be a power of two
READ_LAT, 1, fetch latency in cycles; legal values 1 or 2 (2 adds an output register stage)
RESET_INSTR, 32'h00000013, value driven on fetch_instr when not valid or on error (RV32I NOP)
LA_W, $clog2(DEPTH), derived width of load_addr word index

Ports:
clk  input  1  rising-edge clock
rst_l  input  1  asynchronous active-low reset
load_en  input  1  high requests/holds LOAD state; falling edge ends loading
load_we  input  1  write strobe, honoured only in LOAD
load_addr  input  LA_W  word index to write
load_data  input  DATA_W  instruction word to write
load_count  output  LA_W+1  number of accepted writes since entering LOAD
fetch_ready  output  1  high only in RUN state
fetch_req  input  1  fetch request, accepted when fetch_req && fetch_ready
fetch_addr  input  ADDR_W  byte address; word index = fetch_addr[ADDR_W-1:2]
fetch_valid  output  1  response valid, exactly READ_LAT cycles after acceptance
fetch_instr  output  DATA_W  fetched word; RESET_INSTR when !fetch_valid or fetch_err
fetch_err  output  1  qualified by fetch_valid: misaligned or out-of-range fetch

Behaviour:
- Reset (rst_l=0, async): state=BOOT, load_count=0, fetch_ready=0, fetch_valid=0, fetch_err=0, fetch_instr=RESET_INSTR, and the response pipeline is cleared. Memory array contents are NOT reset and persist across reset.
- Reset asserted mid-operation aborts any in-flight write or fetch. No response is ever emitted for a request accepted before reset.
- BOOT: load_en=1 -> LOAD at the next edge; otherwise stay in BOOT. No fetches are accepted.
- LOAD: load_count clears to 0 on entry. On each cycle with load_we=1 and load_addr<DEPTH: mem[load_addr]<=load_data, and load_count increments, saturating at DEPTH. Writes with load_addr>=DEPTH are dropped and not counted. load_en=0 -> RUN at the next edge; a write presented in that same cycle is still performed.
- RUN: fetch_ready=1. Each accepted request enters an in-order pipeline of depth READ_LAT. One request per cycle, no backpressure, no bubbles required.
- Fetch error: fetch_addr[1:0]!=0 or word index>=DEPTH. The response arrives with the same latency, fetch_valid=1, fetch_err=1, fetch_instr=RESET_INSTR.
- Good fetch: fetch_valid=1, fetch_err=0, fetch_instr=mem[index] as stored when the request was accepted.
- RUN with load_en=1 -> LOAD at the next edge. fetch_ready drops that same edge, and all in-flight responses are flushed (fetch_valid=0 from that edge onward).
- A word that was never written is undefined (X in simulation). The bench writes every location it fetches.
- fetch_err and fetch_instr are registered; no combinational path from fetch_* inputs to outputs.

Test Plan:
- Reset, load_en=1, write words 0..3 = 0x0062E233, 0xFFC4A303, 0x0064A423, 0xFE420AE3, load_en=0 -> load_count=4, fetch_ready=1 one cycle after load_en falls.
- READ_LAT=1, back-to-back fetch_addr 0x0,0x4,0x8,0xC -> fetch_valid on 4 consecutive cycles starting 1 cycle later, with data in order and fetch_err=0; repeat with READ_LAT=2 -> same data starting 2 cycles after the first request.
- Fetch 0x6 (misaligned) and 0x1000 with DEPTH=1024 (out of range) -> fetch_valid=1, fetch_err=1, fetch_instr=0x00000013 for each.
- Two fetches in flight, then load_en=1 -> no fetch_valid pulses after the transition edge, fetch_ready=0; rewrite word 0 to 0x00000093, return to RUN, fetch 0x0 -> 0x00000093.
- DEPTH=5: load_we at load_addr 5 and 7 -> not written, load_count unchanged; writes to addr 4 counted. rst_l pulsed low mid-RUN with a pending fetch -> fetch_valid=0 immediately; after reload-free BOOT->LOAD->RUN, fetch 0x0 still returns the previously loaded word.
